// File: rtl/emin_sched.sv
// emin_sched -- sweeps the emin engine over rows i = 0..I-1 of the E buffer.
//
// For each row it issues one launch to emin, then collects results j = 0..i
// in order. Each result is written to the E buffer at i*I + j. An
// out-of-order j, or a silent emin, parks the block in ERR with a sticky
// error flag. The E-buffer base address advances by I per row through an
// adder, so there is no multiplier.
//
// Optional feature: define EMIN_SCHED_ARGMIN_EN to track each row's signed
// minimum and its j. The default build ties row_min_out, row_argmin_out and
// row_valid_out to zero.
//
// Ports
//   clk_in, rst_in                  clock, asynchronous active-low reset
//   start_in, abort_in              one-cycle control pulses
//   emin_i_out, emin_valid_out      launch request to emin
//   emin_j_in, emin_data_in,
//   emin_valid_in                   result stream from emin
//   wr_addr_out, wr_data_out,
//   wr_en_out                       E buffer write port (registered)
//   row_min_out, row_argmin_out,
//   row_valid_out                   per-row minimum (EMIN_SCHED_ARGMIN_EN only)
//   busy_out, done_out, error_out   status
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start_in
// LAUNCH   | one-cycle emin_valid_out for row cur_i
// WAIT_ROW | collecting results j = 0..cur_i
// NEXT     | row finished; advance to the next row or finish the sweep
// DRAIN    | aborted; waiting for the in-flight row to end (or timeout)
// DONE     | one-cycle done_out
// ERR      | out-of-order result or timeout; waiting for start_in
module emin_sched #(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  parameter int TIMEOUT   = 255
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic                      abort_in,
  output logic [$clog2(I)-1:0]      emin_i_out,
  output logic                      emin_valid_out,
  input  logic [$clog2(I)-1:0]      emin_j_in,
  input  logic [BIT_WIDTH-1:0]      emin_data_in,
  input  logic                      emin_valid_in,
  output logic [$clog2(I*I)-1:0]    wr_addr_out,
  output logic [BIT_WIDTH-1:0]      wr_data_out,
  output logic                      wr_en_out,
  output logic [BIT_WIDTH-1:0]      row_min_out,
  output logic [$clog2(I)-1:0]      row_argmin_out,
  output logic                      row_valid_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      error_out
);

  localparam int IW = $clog2(I);
  localparam int AW = $clog2(I*I);
  localparam int CW = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_ROW, NEXT, DRAIN, DONE, ERR
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   cur_i, exp_j;
  logic [AW-1:0]   base;
  logic [CW-1:0]   idle_cnt;

  logic start_ok, last_row, row_end, accept, mismatch, timeout_hit;

  assign start_ok    = start_in && (state == IDLE || state == ERR);
  assign last_row    = (cur_i == IW'(I-1));
  assign row_end     = emin_valid_in && (emin_j_in == cur_i);
  assign accept      = (state == WAIT_ROW) && emin_valid_in && !abort_in &&
                       (emin_j_in == exp_j);
  assign mismatch    = (state == WAIT_ROW) && emin_valid_in && !abort_in &&
                       (emin_j_in != exp_j);
  // idle_cnt holds the number of cycles since the last launch or result, so
  // error_out rises exactly TIMEOUT cycles after that activity.
  assign timeout_hit = !emin_valid_in && (idle_cnt == CW'(TIMEOUT-1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_in) state_nxt = LAUNCH;
      LAUNCH:   state_nxt = abort_in ? DRAIN : WAIT_ROW;
      WAIT_ROW: begin
        if (abort_in) begin
          // An aborted result that already ends the row leaves nothing to drain.
          state_nxt = row_end ? IDLE : DRAIN;
        end else if (mismatch || timeout_hit) begin
          state_nxt = ERR;
        end else if (accept && row_end) begin
          state_nxt = NEXT;
        end
      end
      NEXT:     state_nxt = last_row ? DONE : LAUNCH;
      DRAIN:    if (row_end || timeout_hit) state_nxt = IDLE;
      DONE:     state_nxt = IDLE;
      ERR:      if (start_in) state_nxt = LAUNCH;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cur_i       <= '0;
      exp_j       <= '0;
      base        <= '0;
      idle_cnt    <= '0;
      error_out   <= 1'b0;
      wr_en_out   <= 1'b0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
    end else begin
      wr_en_out <= 1'b0;
      if (start_ok) begin
        cur_i     <= '0;
        base      <= '0;
        error_out <= 1'b0;
      end
      if (state == LAUNCH) begin
        exp_j    <= '0;
        idle_cnt <= CW'(1);
      end
      if (state == WAIT_ROW || state == DRAIN) begin
        idle_cnt <= emin_valid_in ? CW'(1) : idle_cnt + CW'(1);
      end
      if (accept) begin
        wr_en_out   <= 1'b1;
        wr_addr_out <= base + AW'(exp_j);
        wr_data_out <= emin_data_in;
        exp_j       <= exp_j + IW'(1);
      end
      if (mismatch || (state == WAIT_ROW && !abort_in && timeout_hit)) begin
        error_out <= 1'b1;
      end
      if (state == NEXT && !last_row) begin
        cur_i <= cur_i + IW'(1);
        base  <= base + AW'(I);
      end
    end
  end

  assign emin_valid_out = (state == LAUNCH);
  assign emin_i_out     = (state == LAUNCH) ? cur_i : '0;
  assign busy_out       = (state != IDLE) && (state != ERR);
  assign done_out       = (state == DONE);

`ifdef EMIN_SCHED_ARGMIN_EN
  logic signed [BIT_WIDTH-1:0] min_q;
  logic [IW-1:0]               arg_q;

  // Strict less-than keeps the lowest j on ties.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      min_q <= '0;
      arg_q <= '0;
    end else if (accept) begin
      if (exp_j == '0 || $signed(emin_data_in) < min_q) begin
        min_q <= $signed(emin_data_in);
        arg_q <= exp_j;
      end
    end
  end

  assign row_min_out    = min_q;
  assign row_argmin_out = arg_q;
  assign row_valid_out  = (state == NEXT);
`else
  assign row_min_out    = '0;
  assign row_argmin_out = '0;
  assign row_valid_out  = 1'b0;
`endif

endmodule

// File: tb/tb_emin_sched.sv
module tb_emin_sched;
  localparam int BW  = 32;
  localparam int NI  = 4;
  localparam int IW  = 2;
  localparam int AW  = 4;
  localparam int LAT = 71;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic start_in = 1'b0, abort_in = 1'b0;
  logic [IW-1:0] emin_i_out, emin_j_in, row_argmin_out;
  logic          emin_valid_out, emin_valid_in;
  logic [BW-1:0] emin_data_in, wr_data_out, row_min_out;
  logic [AW-1:0] wr_addr_out;
  logic          wr_en_out, row_valid_out, busy_out, done_out, error_out;

  logic start_t = 1'b0;
  logic [IW-1:0] i_t, argmin_t;
  logic          valid_t, wr_en_t, row_valid_t, busy_t, done_t, error_t;
  logic [BW-1:0] wr_data_t, row_min_t;
  logic [AW-1:0] wr_addr_t;
  logic [IW-1:0] zero_j = '0;
  logic [BW-1:0] zero_d = '0;
  logic          zero_v = 1'b0;

  always #5 clk_in = ~clk_in;

  emin_sched #(.BIT_WIDTH(BW), .I(NI), .TIMEOUT(255)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .abort_in(abort_in),
    .emin_i_out(emin_i_out), .emin_valid_out(emin_valid_out),
    .emin_j_in(emin_j_in), .emin_data_in(emin_data_in), .emin_valid_in(emin_valid_in),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .wr_en_out(wr_en_out),
    .row_min_out(row_min_out), .row_argmin_out(row_argmin_out), .row_valid_out(row_valid_out),
    .busy_out(busy_out), .done_out(done_out), .error_out(error_out));

  emin_sched #(.BIT_WIDTH(BW), .I(NI), .TIMEOUT(16)) dut_to (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_t), .abort_in(zero_v),
    .emin_i_out(i_t), .emin_valid_out(valid_t),
    .emin_j_in(zero_j), .emin_data_in(zero_d), .emin_valid_in(zero_v),
    .wr_addr_out(wr_addr_t), .wr_data_out(wr_data_t), .wr_en_out(wr_en_t),
    .row_min_out(row_min_t), .row_argmin_out(argmin_t), .row_valid_out(row_valid_t),
    .busy_out(busy_t), .done_out(done_t), .error_out(error_t));

  int checks = 0, errors = 0, done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed { logic [AW-1:0] addr; logic [BW-1:0] data; } wr_t;
  typedef struct packed { logic [BW-1:0] mn; logic [IW-1:0] arg; } row_t;
  wr_t  wr_q[$];
  row_t row_q[$];
  int   launch_q[$];

  task automatic push_wr(input int a, input int d);
    wr_t e;
    e.addr = AW'(a);
    e.data = BW'(d);
    wr_q.push_back(e);
  endtask

  task automatic push_row(input int mn, input int arg);
`ifdef EMIN_SCHED_ARGMIN_EN
    row_t r;
    r.mn  = BW'(mn);
    r.arg = IW'(arg);
    row_q.push_back(r);
`endif
  endtask

  // Monitor: compares every DUT presentation against the queued expectation.
  initial forever begin
    wr_t  e;
    row_t r;
    int   li;
    @(negedge clk_in);
    if (wr_en_out) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected none", wr_addr_out, wr_data_out);
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", 64'(wr_addr_out), 64'(e.addr));
        check("wr_data", 64'(wr_data_out), 64'(e.data));
      end
    end
    if (emin_valid_out) begin
      if (launch_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_launch: got i %0d expected none", emin_i_out);
      end else begin
        li = launch_q.pop_front();
        check("launch_i", 64'(emin_i_out), 64'(li));
      end
    end
    if (done_out) done_cnt++;
`ifdef EMIN_SCHED_ARGMIN_EN
    if (row_valid_out) begin
      if (row_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_row: got min %0d expected none", $signed(row_min_out));
      end else begin
        r = row_q.pop_front();
        check("row_min", 64'(row_min_out), 64'(r.mn));
        check("row_argmin", 64'(row_argmin_out), 64'(r.arg));
      end
    end
`else
    if (row_valid_out || row_min_out != '0 || row_argmin_out != '0) begin
      checks++; errors++;
      $display("FAIL row_outputs_nonzero: got valid %0b min %0d expected 0", row_valid_out, row_min_out);
    end
`endif
  end

  // emin model: after LAT cycles returns j = 0..i, one per cycle.
  bit m_on = 0, use_alt = 0;
  int m_wait, m_i, m_j, skip_row = -1;

  function automatic logic [BW-1:0] emin_val(input int j, input int i);
    int alt[4] = '{5, -7, -7, 2};
    if (use_alt && i == 3) return BW'(alt[j]);
    return BW'(10*i + j);
  endfunction

  initial begin
    emin_valid_in = 1'b0;
    emin_j_in = '0;
    emin_data_in = '0;
    forever begin
      @(negedge clk_in);
      emin_valid_in = 1'b0;
      if (m_on) begin
        if (m_wait > 0) m_wait--;
        else begin
          emin_valid_in = 1'b1;
          emin_j_in = IW'(m_j);
          emin_data_in = emin_val(m_j, m_i);
          if (m_i == skip_row && m_j == 0) m_j = 2;
          else m_j++;
          if (m_j > m_i) m_on = 0;
        end
      end
      if (emin_valid_out && !m_on) begin
        m_on = 1; m_i = int'(emin_i_out); m_j = 0; m_wait = LAT - 1;
      end
    end
  end

  task automatic pulse_start(input bit with_abort);
    @(negedge clk_in);
    start_in = 1'b1;
    abort_in = with_abort;
    @(negedge clk_in);
    start_in = 1'b0;
    abort_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk_in);
      if (!busy_out && !m_on) ok = 1;
    end
    check(name, 64'(ok), 64'd1);
    repeat (3) @(negedge clk_in);
  endtask

  task automatic end_scn(input string name);
    check({name, "_wr_left"}, 64'(wr_q.size()), 64'd0);
    check({name, "_launch_left"}, 64'(launch_q.size()), 64'd0);
`ifdef EMIN_SCHED_ARGMIN_EN
    check({name, "_row_left"}, 64'(row_q.size()), 64'd0);
`else
    check({name, "_row_valid"}, 64'(row_valid_out), 64'd0);
`endif
    wr_q.delete(); launch_q.delete(); row_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, 64'(wr_en_out), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr_out), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data_out), 64'd0);
    check({tag, "_emin_valid"}, 64'(emin_valid_out), 64'd0);
    check({tag, "_emin_i"}, 64'(emin_i_out), 64'd0);
    check({tag, "_busy"}, 64'(busy_out), 64'd0);
    check({tag, "_done"}, 64'(done_out), 64'd0);
    check({tag, "_error"}, 64'(error_out), 64'd0);
    check({tag, "_row_valid"}, 64'(row_valid_out), 64'd0);
    check({tag, "_row_min"}, 64'(row_min_out), 64'd0);
    check({tag, "_row_argmin"}, 64'(row_argmin_out), 64'd0);
  endtask

  // Hand-computed full-sweep addresses (i*4+j) and data (10*i+j) for I=4.
  int a_full[10] = '{0, 4, 5, 8, 9, 10, 12, 13, 14, 15};
  int d_full[10] = '{0, 10, 11, 20, 21, 22, 30, 31, 32, 33};
  int d_alt[10]  = '{0, 10, 11, 20, 21, 22, 5, -7, -7, 2};

  task automatic push_full(input bit alt);
    for (int k = 0; k < 10; k++) push_wr(a_full[k], alt ? d_alt[k] : d_full[k]);
    for (int k = 0; k < 4; k++) launch_q.push_back(k);
    push_row(0, 0); push_row(10, 0); push_row(20, 0);
    if (alt) push_row(-7, 1); else push_row(30, 0);
  endtask

  initial begin
    int  d0, t0, cnt;
    bit  found;

    #1 rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_zero("reset");
    rst_in = 1'b1;

    // abort alone in IDLE does nothing
    @(negedge clk_in); abort_in = 1'b1;
    @(negedge clk_in); abort_in = 1'b0;
    @(negedge clk_in);
    check("abort_idle_ignored", 64'(busy_out), 64'd0);

    // full sweep; start and abort together in IDLE: start wins
    push_full(0);
    d0 = done_cnt;
    pulse_start(1);
    check("start_wins_busy", 64'(busy_out), 64'd1);
    wait_idle("sweep_idle");
    check("sweep_done_once", 64'(done_cnt - d0), 64'd1);
    check("sweep_busy_after", 64'(busy_out), 64'd0);
    check("sweep_error", 64'(error_out), 64'd0);
    end_scn("sweep");

    // row 3 data {5,-7,-7,2}; a start while busy is ignored
    use_alt = 1;
    push_full(1);
    d0 = done_cnt;
    pulse_start(0);
    repeat (100) @(negedge clk_in);
    pulse_start(0);
    wait_idle("alt_idle");
    check("alt_done_once", 64'(done_cnt - d0), 64'd1);
    end_scn("alt");
    use_alt = 0;

    // row 2 returns j = 0 then 2
    skip_row = 2;
    push_wr(0, 0); push_wr(4, 10); push_wr(5, 11); push_wr(8, 20);
    launch_q.push_back(0); launch_q.push_back(1); launch_q.push_back(2);
    push_row(0, 0); push_row(10, 0);
    d0 = done_cnt;
    pulse_start(0);
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk_in);
      if (error_out) found = 1;
    end
    check("err_flag", 64'(found), 64'd1);
    check("err_busy", 64'(busy_out), 64'd0);
    wait_idle("err_model_idle");
    check("err_sticky", 64'(error_out), 64'd1);
    end_scn("err");
    skip_row = -1;
    push_full(0);
    pulse_start(0);
    check("err_cleared", 64'(error_out), 64'd0);
    check("err_restart_busy", 64'(busy_out), 64'd1);
    wait_idle("err_restart_idle");
    check("err_restart_done", 64'(done_cnt - d0), 64'd1);
    end_scn("err_restart");

    // abort during row 2 right after the j=0 write
    push_wr(0, 0); push_wr(4, 10); push_wr(5, 11); push_wr(8, 20);
    launch_q.push_back(0); launch_q.push_back(1); launch_q.push_back(2);
    push_row(0, 0); push_row(10, 0);
    d0 = done_cnt;
    pulse_start(0);
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk_in);
      if (wr_en_out && wr_addr_out == AW'(8)) found = 1;
    end
    check("abort_sync", 64'(found), 64'd1);
    abort_in = 1'b1;
    @(negedge clk_in);
    abort_in = 1'b0;
    check("abort_draining", 64'(busy_out), 64'd1);
    wait_idle("abort_idle");
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_error", 64'(error_out), 64'd0);
    end_scn("abort");

    // reset for one cycle mid-row 1
    push_wr(0, 0); push_wr(4, 10);
    launch_q.push_back(0); launch_q.push_back(1);
    push_row(0, 0);
    pulse_start(0);
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk_in);
      if (wr_en_out && wr_addr_out == AW'(4)) found = 1;
    end
    check("rst_sync", 64'(found), 64'd1);
    #2 rst_in = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk_in);
    rst_in = 1'b1;
    wait_idle("rst_model_idle");
    check("rst_busy", 64'(busy_out), 64'd0);
    end_scn("rst");
    push_full(0);
    d0 = done_cnt;
    pulse_start(0);
    wait_idle("rst_sweep_idle");
    check("rst_sweep_done", 64'(done_cnt - d0), 64'd1);
    end_scn("rst_sweep");

    // timeout instance: emin never answers
    @(negedge clk_in); start_t = 1'b1;
    @(negedge clk_in); start_t = 1'b0;
    found = 0;
    t0 = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (valid_t) found = 1;
      else @(negedge clk_in);
    end
    check("to_launch", 64'(found), 64'd1);
    cnt = 0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk_in);
      cnt++;
      if (error_t) found = 1;
    end
    check("to_error_set", 64'(found), 64'd1);
    check("to_cycles", 64'(cnt), 64'd16);
    check("to_busy", 64'(busy_t), 64'd0);
    check("to_done", 64'(done_t), 64'd0);
    check("to_writes", 64'(wr_en_t), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/emin_sched.md
EMIN_SCHED -- requirements
Module: emin_sched

Interface
REQ-001 Parameter BIT_WIDTH, 32, width of Emin data words.
REQ-002 Parameter I, 160, number of frames; rows i = 0..I-1.
REQ-003 Parameter TIMEOUT, 255, maximum idle cycles between emin results before error.
REQ-004 clk_in  input  1  single clock; all state on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-low.
REQ-006 start_in  input  1  one-cycle pulse; begin a full sweep.
REQ-007 abort_in  input  1  one-cycle pulse; stop the sweep after the in-flight row drains.
REQ-008 emin_i_out  output  $clog2(I)  row index presented to emin.
REQ-009 emin_valid_out  output  1  one-cycle launch pulse to emin input_valid.
REQ-010 emin_j_in  input  $clog2(I)  j_out from emin.
REQ-011 emin_data_in  input  BIT_WIDTH  signed Emin(j,i) from emin.
REQ-012 emin_valid_in  input  1  output_valid from emin.
REQ-013 wr_addr_out  output  $clog2(I*I)  E buffer address, i*I+j.
REQ-014 wr_data_out  output  BIT_WIDTH  E buffer write data.
REQ-015 wr_en_out  output  1  E buffer write strobe.
REQ-016 row_min_out  output  BIT_WIDTH  signed minimum of the finished row.
REQ-017 row_argmin_out  output  $clog2(I)  j of that minimum.
REQ-018 row_valid_out  output  1  one-cycle strobe qualifying row_min/argmin.
REQ-019 busy_out  output  1  high in any state except IDLE and ERR.
REQ-020 done_out  output  1  one-cycle pulse at normal sweep completion.
REQ-021 error_out  output  1  sticky error flag.

Function
REQ-022 States: IDLE, LAUNCH, WAIT_ROW, NEXT, DRAIN, DONE, ERR.
REQ-023 IDLE: start_in -> clear cur_i=0, base=0, error_out=0; go to LAUNCH next cycle.
REQ-024 LAUNCH: emin_valid_out=1 for exactly one cycle with emin_i_out=cur_i, exp_j=0; go to WAIT_ROW.
REQ-025 WAIT_ROW: on emin_valid_in, if emin_j_in==exp_j, then registered write the next cycle with wr_en_out=1, wr_addr_out=base+exp_j, wr_data_out=emin_data_in; exp_j increments.
REQ-026 WAIT_ROW: an accepted result with emin_j_in==cur_i ends the row -> NEXT.
REQ-027 NEXT: row_valid_out pulses; if cur_i==I-1 go to DONE; otherwise cur_i+1, base+I (incremental, no multiplier), go to LAUNCH.
REQ-028 DONE: done_out=1 for one cycle; go to IDLE.
REQ-029 Row i produces i+1 writes; a full sweep produces I*(I+1)/2 writes.
REQ-030 emin_valid_in with emin_j_in!=exp_j in WAIT_ROW: no write; error_out=1; go to ERR.
REQ-031 WAIT_ROW timeout: an idle counter resets on each emin_valid_in and counts otherwise; reaching TIMEOUT sets error_out=1 and goes to ERR.
REQ-032 ERR: busy_out=0; hold until start_in, which behaves as from IDLE.
REQ-033 abort_in in LAUNCH or WAIT_ROW: go to DRAIN; writes and row_valid are suppressed from the abort cycle onward.
REQ-034 DRAIN: wait for emin_valid_in with emin_j_in==cur_i, or timeout; then IDLE with done_out not asserted.
REQ-035 abort_in in IDLE, NEXT, DONE or ERR is ignored; start_in while busy_out=1 is ignored.
REQ-036 Simultaneous start_in and abort_in in IDLE: start wins.
REQ-037 Launch spacing: at least 2 cycles from the last accepted result of a row to the next emin_valid_out, guaranteeing emin has returned to START.

Reset
REQ-038 rst_in low: immediately state=IDLE; cur_i, exp_j, base and the idle counter =0.
REQ-039 rst_in low: all outputs =0, including error_out; row_min_out and row_argmin_out also =0.
REQ-040 Reset mid-sweep discards the row in flight; emin results arriving after reset release are ignored in IDLE.

Configuration
REQ-041 Macro EMIN_SCHED_ARGMIN_EN defined: track the running signed minimum per row; first result loads it; strictly smaller replaces it; ties keep lower j; outputs valid with row_valid_out.
REQ-042 EMIN_SCHED_ARGMIN_EN undefined: no tracking logic; row_min_out=0, row_argmin_out=0, row_valid_out=0 always; all other behaviour unchanged.

Verification
REQ-043 I=4; start; model emin returns Emin(j,i)=10*i+j at 71-cycle latency -> 10 writes to addrs 0,4,5,8,9,10,12,13,14,15 in order; one done_out; busy_out low after.
REQ-044 ARGMIN_EN, I=4, row 3 data {5,-7,-7,2} -> row_min_out=-7, row_argmin_out=1.
REQ-045 Row 2 returns j sequence 0,2 -> error_out=1, no write for j=2, state ERR; a new start_in clears error_out and restarts at i=0.
REQ-046 abort_in during row 2 after j=0 -> no further writes; IDLE after j=2 arrives; done_out stays 0.
REQ-047 TIMEOUT=16, emin silent after launch -> error_out=1 exactly 16 cycles after the last activity.
REQ-048 rst_in low for one cycle mid-row 1 -> all outputs 0 immediately; a subsequent start sweeps from i=0.
